// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR arbiter write-side stages.
package ddr_arb_pkg;

  localparam int unsigned BURST_SIZE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REQ       = 2'd1,
    ST_DATA      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } wr_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  function automatic int unsigned burst_bytes(input int unsigned beats,
                                              input int unsigned data_width);
    return beats * (data_width / 8);
  endfunction

endpackage

// File: rtl/ddr_wr_burst_ctrl_if.sv
// Stream-in / arbiter-write-port bundle of ddr_wr_burst_ctrl.
// OVF_COUNT_O exists only when DDR_WR_OVF_CNT_EN is defined.
interface ddr_wr_burst_ctrl_if #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 64
) ();

  localparam int unsigned LVL_W = ddr_arb_pkg::clog2(FIFO_DEPTH) + 1;

  logic                                  FRAME_START_I;
  logic [AXI_ADDR_WIDTH-1:0]             BASE_ADDR_I;
  logic [AXI_DATA_WIDTH-1:0]             DATA_I;
  logic                                  DATA_VALID_I;
  logic                                  W_ACK_I;
  logic                                  W_DONE_I;
  logic                                  W_REQ_O;
  logic [AXI_ADDR_WIDTH-1:0]             W_START_ADDR_O;
  logic [ddr_arb_pkg::BURST_SIZE_W-1:0]  W_BURST_SIZE_O;
  logic [AXI_DATA_WIDTH-1:0]             W_DATA_O;
  logic                                  W_DATA_VALID_O;
  logic [LVL_W-1:0]                      FIFO_LEVEL_O;
  logic                                  OVERFLOW_O;
`ifdef DDR_WR_OVF_CNT_EN
  logic [15:0]                           OVF_COUNT_O;
`endif

  // Burst controller side: consumes the stream, drives the arbiter write port.
  modport master (
`ifdef DDR_WR_OVF_CNT_EN
    output OVF_COUNT_O,
`endif
    input  FRAME_START_I, BASE_ADDR_I, DATA_I, DATA_VALID_I, W_ACK_I, W_DONE_I,
    output W_REQ_O, W_START_ADDR_O, W_BURST_SIZE_O, W_DATA_O, W_DATA_VALID_O,
    output FIFO_LEVEL_O, OVERFLOW_O
  );

  // Source / arbiter side.
  modport slave (
`ifdef DDR_WR_OVF_CNT_EN
    input  OVF_COUNT_O,
`endif
    output FRAME_START_I, BASE_ADDR_I, DATA_I, DATA_VALID_I, W_ACK_I, W_DONE_I,
    input  W_REQ_O, W_START_ADDR_O, W_BURST_SIZE_O, W_DATA_O, W_DATA_VALID_O,
    input  FIFO_LEVEL_O, OVERFLOW_O
  );

endinterface

// File: rtl/ddr_wr_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; a write coinciding with flush is kept.
module ddr_wr_fwft_fifo
  import ddr_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   rd_data_c,
  output logic [clog2(DEPTH):0]   level,
  output logic                    full_c,
  output logic                    empty_c
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [LW-1:0]         count_q;
  logic                  push_c;
  logic                  pop_c;

  assign full_c    = (count_q == LW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign pop_c     = rd_en & ~empty_c;
  // A pop frees the slot in the same cycle, so a write to a full FIFO still lands.
  assign push_c    = wr_en & (~full_c | pop_c);
  assign rd_data_c = mem_q[rd_ptr_q];
  assign level     = count_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      if (wr_en) mem_q[{AW{1'b0}}] <= wr_data;
    end else if (push_c) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= AW'(wr_en);
      count_q  <= LW'(wr_en);
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_c);
      rd_ptr_q <= rd_ptr_q + AW'(pop_c);
      count_q  <= count_q + LW'(push_c) - LW'(pop_c);
    end
  end

endmodule

// File: rtl/ddr_wr_burst_ctrl.sv
// Buffers an incoming beat stream and issues fixed-length write bursts to the DDR arbiter.
// Define DDR_WR_OVF_CNT_EN to add the saturating dropped-beat counter OVF_COUNT_O.
module ddr_wr_burst_ctrl
  import ddr_arb_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned FIFO_DEPTH     = 64
) (
  input logic                 SYS_CLK_I,
  input logic                 RESET_I,
  ddr_wr_burst_ctrl_if.master bus
);

  localparam int unsigned LVL_W       = clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W       = clog2(BURST_LEN);
  localparam int unsigned BURST_BYTES = burst_bytes(BURST_LEN, AXI_DATA_WIDTH);

  wr_state_e                 state_q;
  wr_state_e                 state_d;
  logic                      pop_c;
  logic                      reload_c;
  logic                      advance_c;
  logic                      drop_c;
  logic                      fifo_rd_en_c;
  logic                      fifo_full_c;
  logic                      fifo_empty_c;
  logic [AXI_DATA_WIDTH-1:0] fifo_rd_data_c;
  logic [LVL_W-1:0]          fifo_level;

  logic                      frame_pending_q;
  logic                      w_req_q;
  logic                      w_valid_q;
  logic                      overflow_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]          beat_cnt_q;

  ddr_wr_fwft_fifo #(
    .DATA_WIDTH (AXI_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (SYS_CLK_I),
    .rst       (RESET_I),
    .flush     (reload_c),
    .wr_en     (bus.DATA_VALID_I),
    .wr_data   (bus.DATA_I),
    .rd_en     (fifo_rd_en_c),
    .rd_data_c (fifo_rd_data_c),
    .level     (fifo_level),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c)
  );

  assign fifo_rd_en_c = pop_c & ~fifo_empty_c;
  assign drop_c       = bus.DATA_VALID_I & fifo_full_c & ~fifo_rd_en_c & ~reload_c;

  always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
    if (RESET_I) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state; each pop loads the following beat into the output register.
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    reload_c  = 1'b0;
    advance_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_pending_q || bus.FRAME_START_I) begin
          reload_c = 1'b1;
        end else if (fifo_level >= LVL_W'(BURST_LEN)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.W_ACK_I) begin
          state_d = ST_DATA;
          pop_c   = 1'b1;
        end
      end
      ST_DATA: begin
        if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
          if (bus.W_DONE_I) begin
            state_d   = ST_IDLE;
            advance_c = 1'b1;
          end else begin
            state_d = ST_WAIT_DONE;
          end
        end else begin
          pop_c = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.W_DONE_I) begin
          state_d   = ST_IDLE;
          advance_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
    if (RESET_I) begin
      w_req_q         <= 1'b0;
      w_valid_q       <= 1'b0;
      w_data_q        <= '0;
      beat_cnt_q      <= '0;
      addr_q          <= '0;
      frame_pending_q <= 1'b0;
      overflow_q      <= 1'b0;
    end else begin
      w_req_q    <= (state_d == ST_REQ);
      w_valid_q  <= (state_d == ST_DATA);
      beat_cnt_q <= (state_q == ST_DATA) ? beat_cnt_q + CNT_W'(1) : '0;
      if (fifo_rd_en_c) w_data_q <= fifo_rd_data_c;

      // Reload wins over the advance of a burst that finished before the pending frame start.
      if (reload_c)       addr_q <= bus.BASE_ADDR_I;
      else if (advance_c) addr_q <= addr_q + AXI_ADDR_WIDTH'(BURST_BYTES);

      if (reload_c)                                     frame_pending_q <= 1'b0;
      else if (bus.FRAME_START_I && state_q != ST_IDLE) frame_pending_q <= 1'b1;

      if (reload_c)    overflow_q <= 1'b0;
      else if (drop_c) overflow_q <= 1'b1;
    end
  end

`ifdef DDR_WR_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge SYS_CLK_I or posedge RESET_I) begin
    if (RESET_I)                             ovf_cnt_q <= '0;
    else if (reload_c)                       ovf_cnt_q <= '0;
    else if (drop_c && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
  end

  assign bus.OVF_COUNT_O = ovf_cnt_q;
`endif

  assign bus.W_REQ_O        = w_req_q;
  assign bus.W_START_ADDR_O = addr_q;
  assign bus.W_BURST_SIZE_O = BURST_SIZE_W'(BURST_LEN - 1);
  assign bus.W_DATA_O       = w_data_q;
  assign bus.W_DATA_VALID_O = w_valid_q;
  assign bus.FIFO_LEVEL_O   = fifo_level;
  assign bus.OVERFLOW_O     = overflow_q;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Scoreboard bench for ddr_wr_burst_ctrl: arbiter model, output monitor, directed frames.
module tb_ddr_wr_burst_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned BL = 16;
  localparam int unsigned FD = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ddr_wr_burst_ctrl_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();

  ddr_wr_burst_ctrl #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .BURST_LEN      (BL),
    .FIFO_DEPTH     (FD)
  ) dut (
    .SYS_CLK_I (clk),
    .RESET_I   (rst),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_beats[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] seq = 64'hD000_0000_0000_0000;
  int ack_delay    = 0;
  int done_delay   = 1;
  bit done_on_last = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Arbiter model: acks after ack_delay REQ cycles, signals done on or after the last beat.
  int req_cnt = 0, arb_beats = 0, done_wait = 0;
  always @(negedge clk) begin
    bus.W_ACK_I  = 1'b0;
    bus.W_DONE_I = 1'b0;
    if (rst) begin
      req_cnt = 0; arb_beats = 0; done_wait = 0;
    end else begin
      if (bus.W_REQ_O) begin
        if (req_cnt >= ack_delay) bus.W_ACK_I = 1'b1;
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
      if (bus.W_DATA_VALID_O) begin
        arb_beats++;
        if (arb_beats == BL) begin
          arb_beats = 0;
          if (done_on_last) bus.W_DONE_I = 1'b1;
          else              done_wait = 1;
        end
      end else if (done_wait > 0) begin
        if (done_wait >= done_delay) begin
          bus.W_DONE_I = 1'b1;
          done_wait = 0;
        end else begin
          done_wait++;
        end
      end
    end
  end

  // Monitor: checks every request and beat against the scoreboard queues.
  logic [AW-1:0] cur_addr = '0;
  bit req_prev = 1'b0;
  int run_len = 0;
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 1'b0;
      run_len  = 0;
    end else begin
      if (bus.W_REQ_O) begin
        if (!req_prev) begin
          if (exp_addr.size() == 0) begin
            total++; bad++;
            $display("FAIL req_unexpected: got addr 0x%0h want no request", bus.W_START_ADDR_O);
          end else begin
            cur_addr = exp_addr.pop_front();
            chk("burst_size", 64'(bus.W_BURST_SIZE_O), 64'(BL - 1));
          end
        end
        chk("req_addr", 64'(bus.W_START_ADDR_O), 64'(cur_addr));
      end
      req_prev = bus.W_REQ_O;
      if (bus.W_DATA_VALID_O) begin
        run_len++;
        if (exp_beats.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_unexpected: got 0x%0h want no beat", bus.W_DATA_O);
        end else begin
          chk("beat", bus.W_DATA_O, exp_beats.pop_front());
        end
      end else if (run_len > 0) begin
        chk("burst_len", 64'(run_len), 64'(BL));
        run_len = 0;
      end
    end
  end

  task automatic drive_beats(input int n, input int keep);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.DATA_I       = seq;
      bus.DATA_VALID_I = 1'b1;
      if (i < keep) exp_beats.push_back(seq);
      seq = seq + 64'd1;
    end
    @(negedge clk);
    bus.DATA_VALID_I = 1'b0;
  endtask

  task automatic frame_start(input logic [AW-1:0] base);
    @(negedge clk);
    bus.BASE_ADDR_I   = base;
    bus.FRAME_START_I = 1'b1;
    @(negedge clk);
    bus.FRAME_START_I = 1'b0;
  endtask

  task automatic wait_valid(input bit lvl, input int budget, input string name);
    int n = 0;
    while (bus.W_DATA_VALID_O !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.W_DATA_VALID_O !== lvl) begin
      bad++;
      $display("FAIL %s: valid stuck at %b after %0d cycles, want %b", name, bus.W_DATA_VALID_O, budget, lvl);
    end
  endtask

  task automatic wait_sb(input int remaining, input int budget, input string name);
    int n = 0;
    while (!(exp_beats.size() == remaining && !bus.W_DATA_VALID_O) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_beats.size() != remaining || bus.W_DATA_VALID_O) begin
      bad++;
      $display("FAIL %s: %0d beats outstanding after %0d cycles, want %0d", name, exp_beats.size(), budget, remaining);
    end
  endtask

  initial begin
    int gap;
    rst = 1'b1;
    bus.FRAME_START_I = 1'b0;
    bus.BASE_ADDR_I   = '0;
    bus.DATA_I        = '0;
    bus.DATA_VALID_I  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(bus.W_REQ_O), 64'd0);
    chk("rst_valid", 64'(bus.W_DATA_VALID_O), 64'd0);
    chk("rst_addr", 64'(bus.W_START_ADDR_O), 64'd0);
    chk("rst_data", bus.W_DATA_O, 64'd0);
    chk("rst_level", 64'(bus.FIFO_LEVEL_O), 64'd0);
    chk("rst_ovf", 64'(bus.OVERFLOW_O), 64'd0);
    chk("rst_bsize", 64'(bus.W_BURST_SIZE_O), 64'd15);
`ifdef DDR_WR_OVF_CNT_EN
    chk("rst_ovf_cnt", 64'(bus.OVF_COUNT_O), 64'd0);
`endif
    rst = 1'b0;

    // 1: single burst, acked after 2 cycles
    ack_delay = 2; done_delay = 3;
    frame_start(32'h1000_0000);
    exp_addr.push_back(32'h1000_0000);
    drive_beats(16, 16);
    wait_sb(0, 200, "t1_drain");
    repeat (8) @(negedge clk);
    chk("t1_next_addr", 64'(bus.W_START_ADDR_O), 64'h1000_0080);
    chk("t1_level", 64'(bus.FIFO_LEVEL_O), 64'd0);

    // 2: 40 continuous beats, late ack, 8 left behind
    ack_delay = 5; done_delay = 3;
    frame_start(32'h2000_0000);
    exp_addr.push_back(32'h2000_0000);
    exp_addr.push_back(32'h2000_0080);
    drive_beats(40, 40);
    wait_sb(8, 300, "t2_drain");
    repeat (8) @(negedge clk);
    chk("t2_level", 64'(bus.FIFO_LEVEL_O), 64'd8);
    chk("t2_addr", 64'(bus.W_START_ADDR_O), 64'h2000_0100);
    chk("t2_req_idle", 64'(bus.W_REQ_O), 64'd0);
    exp_beats.delete();

    // 3: overflow with request left unacked, then drain
    ack_delay = 200; done_delay = 1;
    frame_start(32'h3000_0000);
    chk("t3_flush_level", 64'(bus.FIFO_LEVEL_O), 64'd0);
    for (int k = 0; k < 4; k++) exp_addr.push_back(32'h3000_0000 + 32'(k * 128));
    drive_beats(67, 64);
    chk("t3_level_full", 64'(bus.FIFO_LEVEL_O), 64'd64);
    chk("t3_ovf", 64'(bus.OVERFLOW_O), 64'd1);
`ifdef DDR_WR_OVF_CNT_EN
    chk("t3_ovf_cnt", 64'(bus.OVF_COUNT_O), 64'd3);
`endif
    ack_delay = 0;
    wait_sb(0, 600, "t3_drain");
    repeat (8) @(negedge clk);
    chk("t3_ovf_sticky", 64'(bus.OVERFLOW_O), 64'd1);
    chk("t3_addr", 64'(bus.W_START_ADDR_O), 64'h3000_0200);

    // 4: frame start during DATA; burst completes, then flush and reload
    ack_delay = 1; done_delay = 4;
    frame_start(32'h4000_0000);
    chk("t4_ovf_clear", 64'(bus.OVERFLOW_O), 64'd0);
    exp_addr.push_back(32'h4000_0000);
    fork
      drive_beats(20, 20);
      begin
        wait_valid(1'b1, 100, "t4_burst_start");
        frame_start(32'h5000_0000);
      end
    join
    wait_sb(4, 200, "t4_drain");
    exp_beats.delete();
    repeat (10) @(negedge clk);
    chk("t4_flush_level", 64'(bus.FIFO_LEVEL_O), 64'd0);
    chk("t4_reload_addr", 64'(bus.W_START_ADDR_O), 64'h5000_0000);
    chk("t4_req_idle", 64'(bus.W_REQ_O), 64'd0);

    // 5: address wraps past the top of the address space
    ack_delay = 0; done_delay = 1;
    frame_start(32'hFFFF_FFC0);
    exp_addr.push_back(32'hFFFF_FFC0);
    exp_addr.push_back(32'h0000_0040);
    drive_beats(32, 32);
    wait_sb(0, 300, "t5_drain");
    repeat (8) @(negedge clk);
    chk("t5_addr", 64'(bus.W_START_ADDR_O), 64'h0000_00C0);

    // 6: done on the last beat returns straight to IDLE
    ack_delay = 0; done_on_last = 1'b1;
    frame_start(32'h6000_0000);
    exp_addr.push_back(32'h6000_0000);
    exp_addr.push_back(32'h6000_0080);
    fork
      drive_beats(32, 32);
      begin
        wait_valid(1'b1, 100, "t6_first_burst");
        wait_valid(1'b0, 50, "t6_first_end");
        gap = 0;
        while (!bus.W_REQ_O && gap < 50) begin
          @(negedge clk);
          gap++;
        end
        chk("t6_idle_gap", 64'(gap), 64'd1);
      end
    join
    wait_sb(0, 200, "t6_drain");
    repeat (8) @(negedge clk);
    chk("t6_addr", 64'(bus.W_START_ADDR_O), 64'h6000_0100);
    done_on_last = 1'b0;

    chk("left_requests", 64'(exp_addr.size()), 64'd0);
    chk("left_beats", 64'(exp_beats.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
